// File: rtl/gather_buffer.sv
// Gathers the serial fp32 result stream from lane0 into NrLanes x ELEN store beats.
// Two beat slots ping-pong: one fills from lane0 while the other drains per lane.

package gather_buffer_pkg;
  localparam int unsigned ELEN    = 64;
  localparam int unsigned FpWidth = 32;

  typedef logic [ELEN-1:0] elen_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

module gather_buffer
  import gather_buffer_pkg::*;
#(
  parameter int unsigned NrLanes  = 4,
  parameter int unsigned MAX_GLEN = 32,
  parameter int unsigned LenWidth = $clog2(MAX_GLEN) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [LenWidth-1:0]       len_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic                      done_o,
  input  logic [FpWidth-1:0]        gt_data_i,
  input  logic                      gt_valid_i,
  output logic                      gt_ready_o,
  output elen_t [NrLanes-1:0]       stu_operand_o,
  output logic  [NrLanes-1:0]       stu_operand_valid_o,
  input  logic  [NrLanes-1:0]       stu_operand_ready_i,
  output logic                      dbg_state_o
);

  // Handshakes: a transfer happens on every rising clk_i where valid and ready
  // are both high; valid never depends on ready, and an offered item is held
  // until it is taken.

  localparam int unsigned B    = 2 * NrLanes;
  localparam int unsigned IdxW = (B > 1) ? $clog2(B) : 1;

  if (MAX_GLEN % NrLanes != 0) begin : g_bad_cfg
    $error("gather_buffer: MAX_GLEN must be a multiple of NrLanes");
  end

  state_e                    state_q;
  elen_t [NrLanes-1:0]       slot_data_q  [2];
  logic  [NrLanes-1:0]       slot_valid_q [2];
  logic                      wr_ptr_q;
  logic                      rd_ptr_q;
  logic  [IdxW-1:0]          idx_q;
  logic  [LenWidth-1:0]      remaining_q;
  logic  [LenWidth-1:0]      beats_left_q;
  logic                      done_zero_q;

  logic                      wr_empty;
  logic                      fill_hs;
  logic                      close_beat;
  logic  [NrLanes-1:0]       rd_valid;
  logic  [NrLanes-1:0]       drain_fire;
  logic  [NrLanes-1:0]       rd_valid_next;
  logic                      rd_drained;
  logic                      last_drain;
  logic  [LenWidth:0]        len_round;
  logic  [LenWidth-1:0]      start_beats;
  elen_t [NrLanes-1:0]       beat_d;

  // Fill side.
  assign wr_empty   = ~|slot_valid_q[wr_ptr_q];
  assign gt_ready_o = (state_q == RUN) && wr_empty && (remaining_q != '0);
  assign fill_hs    = gt_valid_i && gt_ready_o;
  assign close_beat = fill_hs &&
                      ((idx_q == IdxW'(B - 1)) || (remaining_q == LenWidth'(1)));

  // Drain side: each lane retires its own valid bit.
  assign rd_valid      = slot_valid_q[rd_ptr_q];
  assign drain_fire    = rd_valid & stu_operand_ready_i;
  assign rd_valid_next = rd_valid & ~drain_fire;
  assign rd_drained    = (|rd_valid) && (rd_valid_next == '0);
  assign last_drain    = rd_drained && (beats_left_q == LenWidth'(1));

  assign stu_operand_o       = slot_data_q[rd_ptr_q];
  assign stu_operand_valid_o = rd_valid;

  assign busy_o      = (state_q == RUN);
  assign done_o      = done_zero_q || (last_drain && !abort_i);
  assign dbg_state_o = state_q;

  // Beat count is ceil(len / B).
  assign len_round   = {1'b0, len_i} + (LenWidth + 1)'(B - 1);
  assign start_beats = LenWidth'(len_round / (LenWidth + 1)'(B));

  // The first element of a beat clears the slot, so positions never written
  // before the beat closes read back as zero padding.
  always_comb begin
    beat_d = (idx_q == '0) ? '0 : slot_data_q[wr_ptr_q];
    for (int e = 0; e < B; e++) begin
      if (idx_q == IdxW'(e)) begin
        beat_d[e % NrLanes][FpWidth*(e / NrLanes) +: FpWidth] = gt_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      slot_data_q[0]  <= '0;
      slot_data_q[1]  <= '0;
      slot_valid_q[0] <= '0;
      slot_valid_q[1] <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      idx_q           <= '0;
      remaining_q     <= '0;
      beats_left_q    <= '0;
      done_zero_q     <= 1'b0;
    end else begin
      done_zero_q <= 1'b0;
      if (abort_i) begin
        state_q         <= IDLE;
        slot_valid_q[0] <= '0;
        slot_valid_q[1] <= '0;
        wr_ptr_q        <= 1'b0;
        rd_ptr_q        <= 1'b0;
        idx_q           <= '0;
        remaining_q     <= '0;
        beats_left_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              if (len_i == '0) begin
                done_zero_q <= 1'b1;
              end else begin
                state_q         <= RUN;
                remaining_q     <= len_i;
                beats_left_q    <= start_beats;
                idx_q           <= '0;
                wr_ptr_q        <= 1'b0;
                rd_ptr_q        <= 1'b0;
                slot_valid_q[0] <= '0;
                slot_valid_q[1] <= '0;
              end
            end
          end
          RUN: begin
            if (fill_hs) begin
              slot_data_q[wr_ptr_q] <= beat_d;
              remaining_q           <= remaining_q - LenWidth'(1);
              if (close_beat) begin
                slot_valid_q[wr_ptr_q] <= '1;
                idx_q                  <= '0;
                wr_ptr_q               <= ~wr_ptr_q;
              end else begin
                idx_q <= idx_q + IdxW'(1);
              end
            end
            // A closing write needs an empty write slot, so it never targets
            // the slot currently draining.
            if (|drain_fire) begin
              slot_valid_q[rd_ptr_q] <= rd_valid_next;
            end
            if (rd_drained) begin
              rd_ptr_q     <= ~rd_ptr_q;
              beats_left_q <= beats_left_q - LenWidth'(1);
              if (last_drain) begin
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gather_buffer.sv
// Directed bench for gather_buffer: packing, padding, per-lane backpressure,
// abort, zero-length and ignored starts, and asynchronous reset mid-drain.

module tb_gather_buffer;

  localparam int NrLanes  = 4;
  localparam int MAX_GLEN = 32;
  localparam int LenWidth = 6;

  // Clock / reset
  logic clk     = 1'b0;
  logic rst_ni  = 1'b0;
  always #5 clk = ~clk;

  logic                      start_i = 1'b0;
  logic [LenWidth-1:0]       len_i   = '0;
  logic                      abort_i = 1'b0;
  logic                      busy_o;
  logic                      done_o;
  logic [31:0]               gt_data_i  = '0;
  logic                      gt_valid_i = 1'b0;
  logic                      gt_ready_o;
  logic [NrLanes-1:0][63:0]  stu_operand_o;
  logic [NrLanes-1:0]        stu_valid;
  logic [NrLanes-1:0]        stu_ready = '1;
  logic                      dbg_state;

  gather_buffer #(
    .NrLanes  (NrLanes),
    .MAX_GLEN (MAX_GLEN),
    .LenWidth (LenWidth)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .start_i             (start_i),
    .len_i               (len_i),
    .abort_i             (abort_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .gt_data_i           (gt_data_i),
    .gt_valid_i          (gt_valid_i),
    .gt_ready_o          (gt_ready_o),
    .stu_operand_o       (stu_operand_o),
    .stu_operand_valid_o (stu_valid),
    .stu_operand_ready_i (stu_ready),
    .dbg_state_o         (dbg_state)
  );

  // Scoreboard state
  int          checks = 0;
  int          errors = 0;
  int          done_cnt;
  int          acc_cnt;
  logic        busy_at_done;
  logic [31:0] src_q [$];
  logic [63:0] obs_q [NrLanes][$];
  logic [63:0] exp_q [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic clear_sb();
    src_q.delete();
    exp_q.delete();
    for (int l = 0; l < NrLanes; l++) obs_q[l].delete();
    done_cnt     = 0;
    acc_cnt      = 0;
    busy_at_done = 1'b0;
  endtask

  // One clock cycle: drive lane0 from src_q, record handshakes, advance to next negedge.
  task automatic tick();
    gt_valid_i = (src_q.size() > 0);
    gt_data_i  = (src_q.size() > 0) ? src_q[0] : 32'h0;
    #1;
    for (int l = 0; l < NrLanes; l++)
      if (stu_valid[l] && stu_ready[l]) obs_q[l].push_back(stu_operand_o[l]);
    if (done_o) begin
      done_cnt++;
      busy_at_done = busy_o;
    end
    if (gt_valid_i && gt_ready_o && !abort_i) begin
      void'(src_q.pop_front());
      acc_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_burst(input int len);
    for (int i = 1; i <= len; i++) src_q.push_back(32'(i));
    len_i   = LenWidth'(len);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string name);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_done_timeout: done_o count %0d after %0d cycles, required 1", name, done_cnt, budget);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    #2;
    checks++;
    if ({busy_o, done_o, gt_ready_o, dbg_state} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/ready/state=%b, required 0000", {busy_o, done_o, gt_ready_o, dbg_state});
    end
    checks++;
    if (stu_valid !== '0 || stu_operand_o !== '0) begin
      errors++;
      $display("FAIL reset_stu: valid=%b operand=%h, required 0/0", stu_valid, stu_operand_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_single_beat(input string name);
    clear_sb();
    stu_ready = '1;
    exp_q.push_back(64'h00000005_00000001);
    exp_q.push_back(64'h00000006_00000002);
    exp_q.push_back(64'h00000007_00000003);
    exp_q.push_back(64'h00000008_00000004);
    start_burst(8);
    run_until_done(60, name);
    checks++;
    if (busy_at_done !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: busy at done=%b after=%b, required 1/0", name, busy_at_done, busy_o);
    end
    tick();
    tick();
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt);
    end
    for (int l = 0; l < NrLanes; l++) begin
      checks++;
      if (obs_q[l].size() != 1) begin
        errors++;
        $display("FAIL %s_lane%0d_beats: got %0d, required 1", name, l, obs_q[l].size());
      end else if (obs_q[l][0] !== exp_q[l]) begin
        errors++;
        $display("FAIL %s_lane%0d_data: got %h, required %h", name, l, obs_q[l][0], exp_q[l]);
      end
    end
  endtask

  task automatic test_partial_beat();
    clear_sb();
    exp_q.push_back(64'h00000005_00000001);
    exp_q.push_back(64'h00000006_00000002);
    exp_q.push_back(64'h00000007_00000003);
    exp_q.push_back(64'h00000008_00000004);
    exp_q.push_back(64'h00000000_00000009);
    exp_q.push_back(64'h00000000_0000000A);
    exp_q.push_back(64'h00000000_0000000B);
    exp_q.push_back(64'h00000000_00000000);
    start_burst(11);
    run_until_done(80, "t2");
    tick();
    tick();
    for (int l = 0; l < NrLanes; l++) begin
      checks++;
      if (obs_q[l].size() != 2) begin
        errors++;
        $display("FAIL t2_lane%0d_beats: got %0d, required 2", l, obs_q[l].size());
      end else begin
        for (int b = 0; b < 2; b++) begin
          checks++;
          if (obs_q[l][b] !== exp_q[b*NrLanes+l]) begin
            errors++;
            $display("FAIL t2_b%0d_lane%0d: got %h, required %h", b, l, obs_q[l][b], exp_q[b*NrLanes+l]);
          end
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL t2_done_count: got %0d, required 1", done_cnt);
    end
  endtask

  task automatic test_backpressure();
    clear_sb();
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < NrLanes; l++)
        exp_q.push_back({32'(8*k + l + 5), 32'(8*k + l + 1)});
    stu_ready    = '1;
    stu_ready[2] = 1'b0;
    start_burst(24);
    for (int i = 0; i < 150 && done_cnt == 0; i++) begin
      stu_ready[2] = (i >= 30);
      tick();
      if (i == 25) begin
        checks++;
        if (acc_cnt != 16 || gt_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL t3_stall: accepted %0d ready=%b, required 16/0", acc_cnt, gt_ready_o);
        end
        checks++;
        if (obs_q[0].size() != 1 || obs_q[1].size() != 1 || obs_q[3].size() != 1 || obs_q[2].size() != 0) begin
          errors++;
          $display("FAIL t3_partial_drain: lane beats %0d/%0d/%0d/%0d, required 1/1/0/1",
                   obs_q[0].size(), obs_q[1].size(), obs_q[2].size(), obs_q[3].size());
        end
      end
      if (i == 29) begin
        checks++;
        if (acc_cnt != 16) begin
          errors++;
          $display("FAIL t3_no_resume: accepted %0d before lane2 ready, required 16", acc_cnt);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || acc_cnt != 24) begin
      errors++;
      $display("FAIL t3_complete: done %0d accepted %0d, required 1/24", done_cnt, acc_cnt);
    end
    for (int l = 0; l < NrLanes; l++) begin
      checks++;
      if (obs_q[l].size() != 3) begin
        errors++;
        $display("FAIL t3_lane%0d_beats: got %0d, required 3", l, obs_q[l].size());
      end else begin
        for (int b = 0; b < 3; b++) begin
          checks++;
          if (obs_q[l][b] !== exp_q[b*NrLanes+l]) begin
            errors++;
            $display("FAIL t3_b%0d_lane%0d: got %h, required %h", b, l, obs_q[l][b], exp_q[b*NrLanes+l]);
          end
        end
      end
    end
    stu_ready = '1;
    tick();
  endtask

  task automatic test_abort();
    clear_sb();
    start_burst(16);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (acc_cnt != 5) begin
      errors++;
      $display("FAIL t4_pre_abort: accepted %0d, required 5", acc_cnt);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    src_q.delete();
    checks++;
    if (stu_valid !== '0 || busy_o !== 1'b0 || gt_ready_o !== 1'b0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL t4_after_abort: valid=%b busy=%b ready=%b state=%b, required 0", stu_valid, busy_o, gt_ready_o, dbg_state);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL t4_no_done: done_o count %0d, required 0", done_cnt);
    end
    test_single_beat("t4_restart");
  endtask

  task automatic test_len_zero_and_ignore();
    clear_sb();
    len_i   = '0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL t5_zero_early: done_o seen in start cycle, required next cycle");
    end
    tick();
    tick();
    checks++;
    if (done_cnt != 1 || busy_o !== 1'b0 || obs_q[0].size() != 0 || obs_q[3].size() != 0) begin
      errors++;
      $display("FAIL t5_zero_len: done %0d busy %b beats %0d, required 1/0/0", done_cnt, busy_o, obs_q[0].size());
    end
    clear_sb();
    for (int k = 0; k < 2; k++)
      for (int l = 0; l < NrLanes; l++)
        exp_q.push_back({32'(8*k + l + 5), 32'(8*k + l + 1)});
    start_burst(16);
    tick();
    tick();
    len_i   = LenWidth'(8);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    run_until_done(80, "t5");
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (done_cnt != 1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL t5_ignored_start: done %0d busy %b, required 1/0", done_cnt, busy_o);
    end
    for (int l = 0; l < NrLanes; l++) begin
      checks++;
      if (obs_q[l].size() != 2) begin
        errors++;
        $display("FAIL t5_lane%0d_beats: got %0d, required 2", l, obs_q[l].size());
      end else begin
        for (int b = 0; b < 2; b++) begin
          checks++;
          if (obs_q[l][b] !== exp_q[b*NrLanes+l]) begin
            errors++;
            $display("FAIL t5_b%0d_lane%0d: got %h, required %h", b, l, obs_q[l][b], exp_q[b*NrLanes+l]);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    clear_sb();
    stu_ready = '0;
    start_burst(16);
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (stu_valid !== 4'hF || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL t6_pre_reset: valid=%b busy=%b, required 1111/1", stu_valid, busy_o);
    end
    #3;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, gt_ready_o, dbg_state} !== 4'b0000 || stu_valid !== '0 || stu_operand_o !== '0) begin
      errors++;
      $display("FAIL t6_async_reset: ctrl=%b valid=%b operand=%h, required all 0",
               {busy_o, done_o, gt_ready_o, dbg_state}, stu_valid, stu_operand_o);
    end
    @(negedge clk);
    rst_ni    = 1'b1;
    stu_ready = '1;
    clear_sb();
    tick();
    test_single_beat("t6_after_reset");
  endtask

  initial begin
    test_reset();
    test_single_beat("t1");
    test_partial_beat();
    test_backpressure();
    test_abort();
    test_len_zero_and_ignore();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
